vga_bmp_arb: RTL and testbench

VGA_BMP_ARB -- requirements
Module: vga_bmp_arb

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_wr_fifo.sv | 69 ++++++
 rtl/vga_bmp_arb.sv | 145 ++++++++++++++
 tb/tb_vga_bmp_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the bitmap RAM arbiter.
//   - default widths/depth for the bitmap address, data and host write FIFO
//   - arbiter grant encoding (IDLE/SCAN/WRITE), kept as plain 2-bit constants
package vga_pkg;

  localparam int AW_DEF    = 6;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_SCAN  = 2'd1;
  localparam arb_state_t ST_WRITE = 2'd2;

endpackage

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: host write queue of {addr,data} entries.
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_addr/data  : enqueue at tail (caller guarantees not full)
//   pop                   : dequeue head (caller guarantees not empty)
//   head_addr, head_data  : current head entry, valid while empty=0
//   count                 : registered occupancy, 0..DEPTH
//   full, empty           : decoded from the registered count only
module vga_wr_fifo #(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset: contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= {push_addr, push_data};
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is read straight from the array so a pop can commit in the same
  // cycle it is granted; a fresh push is only visible once count has moved.
  assign {head_addr, head_data} = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/vga_bmp_arb.sv
// vga_bmp_arb: single-port bitmap RAM arbiter between VGA scanout and host.
//   clk, rst_n                 : pixel clock, asynchronous active-low reset
//   vblank                     : high outside the active vertical window
//   sc_req, sc_addr            : scanout read request/address (always wins)
//   sc_q, sc_vld               : read data (straight from ram_q), valid 2 cycles after sc_req
//   h_wr, h_addr, h_data       : host write strobe/address/data into the FIFO
//   h_full                     : FIFO holds DEPTH entries
//   ovf, ovf_clr               : sticky drop flag and its clear (set wins)
//   ram_addr, ram_wdata, ram_we: registered RAM command
//   ram_q                      : RAM read data, 1 cycle after ram_addr
module vga_bmp_arb
  import vga_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int VB_ONLY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vblank,
  input  logic          sc_req,
  input  logic [AW-1:0] sc_addr,
  output logic [DW-1:0] sc_q,
  output logic          sc_vld,
  input  logic          h_wr,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_data,
  output logic          h_full,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic                  r_sc_d1;
  logic                  r_sc_d2;
  logic                  r_ovf;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_wr_window;
  logic [AW-1:0]         w_head_addr;
  logic [DW-1:0]         w_head_data;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_unused_count;

  // Full comes from the registered count, so a same-cycle pop never frees
  // room for a push: a write at full is always dropped.
  assign w_push = h_wr & ~w_full;
  assign w_drop = h_wr &  w_full;

  assign w_wr_window = vblank | (VB_ONLY == 0);

  vga_wr_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_addr (h_addr),
    .push_data (h_data),
    .pop       (w_pop),
    .head_addr (w_head_addr),
    .head_data (w_head_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Occupancy is available for observation; arbitration only needs the flags.
  assign w_unused_count = ^w_count;

  // Grant selection: scanout first, then a pending write if the window allows.
  always_comb begin
    w_state_next = ST_IDLE;
    w_pop        = 1'b0;
    if (sc_req) begin
      w_state_next = ST_SCAN;
    end else if (!w_empty && w_wr_window) begin
      w_state_next = ST_WRITE;
      w_pop        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      case (w_state_next)
        ST_SCAN: begin
          ram_addr <= sc_addr;
        end
        ST_WRITE: begin
          ram_addr  <= w_head_addr;
          ram_wdata <= w_head_data;
        end
        default: begin
          // IDLE: address and data bus hold their last values
        end
      endcase
    end
  end

  // The registered grant is the write enable.
  assign ram_we = (r_state == ST_WRITE);

  // Two-stage valid pipe: one for the address register, one for the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc_d1 <= 1'b0;
      r_sc_d2 <= 1'b0;
    end else begin
      r_sc_d1 <= sc_req;
      r_sc_d2 <= r_sc_d1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign sc_q   = ram_q;
  assign sc_vld = r_sc_d2;
  assign h_full = w_full;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_vga_bmp_arb.sv
// tb_vga_bmp_arb: directed stimulus for vga_bmp_arb with a queue-based
// reference model checked every cycle, plus literal checks per scenario.
module tb_vga_bmp_arb;

  localparam int AW      = 6;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int VB_ONLY = 1;

  logic          clk;
  logic          rst_n;
  logic          vblank;
  logic          sc_req;
  logic [AW-1:0] sc_addr;
  logic [DW-1:0] sc_q;
  logic          sc_vld;
  logic          h_wr;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  logic          h_full;
  logic          ovf;
  logic          ovf_clr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int checks   = 0;
  int failures = 0;

  vga_bmp_arb #(
    .AW      (AW),
    .DW      (DW),
    .DEPTH   (DEPTH),
    .VB_ONLY (VB_ONLY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblank    (vblank),
    .sc_req    (sc_req),
    .sc_addr   (sc_addr),
    .sc_q      (sc_q),
    .sc_vld    (sc_vld),
    .h_wr      (h_wr),
    .h_addr    (h_addr),
    .h_data    (h_data),
    .h_full    (h_full),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-port RAM (read-first, 1-cycle latency) --------
  // Unwritten bytes read as addr ^ 0xA0, so byte[5] = 0xA5.
  logic [DW-1:0] ram     [64];
  bit            ram_wr  [64];

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr]    <= ram_wdata;
      ram_wr[ram_addr] <= 1'b1;
    end
    ram_q <= ram_wr[ram_addr] ? ram[ram_addr] : ({2'b00, ram_addr} ^ 8'hA0);
  end

  // ---------------- reference model --------------------------------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  ent_t          m_e;
  logic [DW-1:0] refmem [64];
  logic          m_we, m_ovf, m_v1, m_v2;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_d1, m_d2;
  int            m_sz;

  initial begin
    for (int i = 0; i < 64; i++) refmem[i] = 8'(i) ^ 8'hA0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_we = 1'b0; m_ovf = 1'b0; m_v1 = 1'b0; m_v2 = 1'b0;
      m_addr = '0; m_wdata = '0; m_d1 = '0; m_d2 = '0;
    end else begin
      m_sz = m_q.size();
      m_v2 = m_v1;
      m_d2 = m_d1;
      m_v1 = sc_req;
      m_d1 = refmem[sc_addr];
      if (sc_req) begin
        m_we   = 1'b0;
        m_addr = sc_addr;
      end else if (m_sz > 0 && (vblank || VB_ONLY == 0)) begin
        m_e     = m_q.pop_front();
        m_we    = 1'b1;
        m_addr  = m_e.a;
        m_wdata = m_e.d;
        refmem[m_e.a] = m_e.d;
      end else begin
        m_we = 1'b0;
      end
      if (h_wr && m_sz == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)          m_ovf = 1'b0;
      if (h_wr && m_sz < DEPTH) m_q.push_back({h_addr, h_data});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_ram_we", ram_we, m_we);
    chk("m_ram_addr", ram_addr, m_addr);
    chk("m_ram_wdata", ram_wdata, m_wdata);
    chk("m_h_full", h_full, (m_q.size() == DEPTH));
    chk("m_ovf", ovf, m_ovf);
    chk("m_sc_vld", sc_vld, m_v2);
    if (m_v2) chk("m_sc_q", sc_q, m_d2);
    if (rst_n && ram_we) $display("commit addr=%0d data=%02h", ram_addr, ram_wdata);
    if (rst_n && sc_vld) $display("scan   data=%02h", sc_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_wr = 1'b1; h_addr = a; h_data = d;
    tick();
    h_wr = 1'b0;
  endtask

  // ---------------- directed stimulus ------------------------------------
  initial begin
    rst_n = 1'b0; vblank = 1'b0; sc_req = 1'b0; sc_addr = '0;
    h_wr = 1'b0; h_addr = '0; h_data = '0; ovf_clr = 1'b0;
    #2;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_h_full", h_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sc_vld", sc_vld, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Scanout read of byte 5
    sc_req = 1'b1; sc_addr = 6'd5;
    tick();
    sc_req = 1'b0;
    chk("s1_ram_addr", ram_addr, 5);
    chk("s1_ram_we", ram_we, 0);
    chk("s1_vld_early", sc_vld, 0);
    tick();
    chk("s1_sc_vld", sc_vld, 1);
    chk("s1_sc_q", sc_q, 8'hA5);
    tick();
    chk("s1_vld_end", sc_vld, 0);

    // Writes held off outside vblank, then drained in order
    host_push(6'd10, 8'h11);
    host_push(6'd11, 8'h22);
    host_push(6'd12, 8'h33);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_hold_we", ram_we, 0);
    end
    vblank = 1'b1;
    tick(); chk("s2_we0", ram_we, 1); chk("s2_a0", ram_addr, 10); chk("s2_d0", ram_wdata, 8'h11);
    tick(); chk("s2_we1", ram_we, 1); chk("s2_a1", ram_addr, 11); chk("s2_d1", ram_wdata, 8'h22);
    tick(); chk("s2_we2", ram_we, 1); chk("s2_a2", ram_addr, 12); chk("s2_d2", ram_wdata, 8'h33);
    tick(); chk("s2_done", ram_we, 0);
    vblank = 1'b0;

    // Fill, overflow, clear, set-wins, reject at full with same-cycle pop
    for (int i = 0; i < 4; i++) host_push(6'(20 + i), 8'(8'h80 + i));
    chk("s3_full", h_full, 1);
    host_push(6'd24, 8'h84);
    chk("s3_ovf_set", ovf, 1);
    ovf_clr = 1'b1; tick();
    chk("s3_ovf_clr", ovf, 0);
    h_wr = 1'b1; h_addr = 6'd24; h_data = 8'h84;
    tick();
    chk("s3_set_wins", ovf, 1);
    h_wr = 1'b0; tick();
    chk("s3_ovf_clr2", ovf, 0);
    ovf_clr = 1'b0;
    vblank = 1'b1; h_wr = 1'b1; h_addr = 6'd25; h_data = 8'h99;
    tick();
    h_wr = 1'b0;
    chk("s3_rej_ovf", ovf, 1);
    chk("s3_rej_full", h_full, 0);
    chk("s3_rej_a", ram_addr, 20);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("s3_a21", ram_addr, 21);
    tick(); chk("s3_a22", ram_addr, 22);
    tick(); chk("s3_a23", ram_addr, 23); chk("s3_d23", ram_wdata, 8'h83);
    tick(); chk("s3_done", ram_we, 0);
    vblank = 1'b0;

    // Scanout priority over pending writes during vblank
    host_push(6'd30, 8'h5A);
    host_push(6'd31, 8'h6B);
    vblank = 1'b1; sc_req = 1'b1; sc_addr = 6'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_blocked", ram_we, 0);
    end
    sc_req = 1'b0;
    tick(); chk("s4_we0", ram_we, 1); chk("s4_a0", ram_addr, 30);
    tick(); chk("s4_we1", ram_we, 1); chk("s4_a1", ram_addr, 31); chk("s4_d1", ram_wdata, 8'h6B);
    tick(); chk("s4_done", ram_we, 0);
    sc_req = 1'b1; sc_addr = 6'd30;
    tick(); sc_req = 1'b0;
    tick();
    chk("s4_rb_vld", sc_vld, 1);
    chk("s4_rb_q", sc_q, 8'h5A);
    vblank = 1'b0;

    // Push and pop together at count 2
    host_push(6'd40, 8'h44);
    host_push(6'd41, 8'h45);
    chk("s5_cnt2", dut.u_fifo.count, 2);
    vblank = 1'b1;
    host_push(6'd42, 8'h46);
    chk("s5_cnt_hold", dut.u_fifo.count, 2);
    chk("s5_a40", ram_addr, 40);
    tick(); chk("s5_a41", ram_addr, 41);
    tick(); chk("s5_a42", ram_addr, 42); chk("s5_d42", ram_wdata, 8'h46);
    tick(); chk("s5_done", ram_we, 0); chk("s5_cnt0", dut.u_fifo.count, 0);
    vblank = 1'b0;

    // Reset with a full queue, overflow and a scanout in flight
    for (int i = 0; i < 5; i++) host_push(6'(50 + i), 8'(8'hC0 + i));
    chk("s6_pre_ovf", ovf, 1);
    sc_req = 1'b1; sc_addr = 6'd7;
    tick();
    sc_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("s6_rst_full", h_full, 0);
    chk("s6_rst_ovf", ovf, 0);
    chk("s6_rst_vld", sc_vld, 0);
    chk("s6_rst_we", ram_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; vblank = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_no_we", ram_we, 0);
      chk("s6_no_vld", sc_vld, 0);
    end
    vblank = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
